// File: rtl/piso.sv
// Byte-to-bit serializer feeding the convolutional encoder, LSB first, with an
// optional zero tail per frame enabled by defining PISO_TAIL_FLUSH_EN.
module piso #(
    parameter int TAIL_BITS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_parallel_i,
    input  logic       byte_valid_i,
    input  logic       byte_last_i,
    output logic       byte_ready_o,
    output logic       data_serial_o,
    output logic       valid_serial_o,
    input  logic       serial_ready_i,
    output logic       last_serial_o,
    output logic       busy_o
);

    // Handshakes: a byte moves on a rising edge with byte_valid_i && byte_ready_o;
    // a bit moves on a rising edge with valid_serial_o && serial_ready_i.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        TAIL  = 2'd2
    } state_t;

    if (TAIL_BITS < 1 || TAIL_BITS > 15) begin : g_bad_tail_bits
        $error("piso: TAIL_BITS must be within 1..15");
    end

    state_t     state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] cnt_q, cnt_d;
    logic       frame_last_q, frame_last_d;
    logic       ready_en_q;
    logic       valid_q, valid_d;
    logic       last_out_q, last_out_d;

`ifdef PISO_TAIL_FLUSH_EN
    localparam logic [3:0] TAIL_END = 4'(TAIL_BITS - 1);
    logic [3:0] tail_cnt_q, tail_cnt_d;
`endif

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        frame_last_d = frame_last_q;
        byte_ready_o = 1'b0;
`ifdef PISO_TAIL_FLUSH_EN
        tail_cnt_d   = tail_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                // ready_en_q keeps the input closed for one cycle after reset.
                byte_ready_o = ready_en_q;
                if (byte_valid_i && ready_en_q) begin
                    shreg_d      = data_parallel_i;
                    frame_last_d = byte_last_i;
                    cnt_d        = 3'd0;
                    state_d      = SHIFT;
                end
            end
            SHIFT: begin
                byte_ready_o = (cnt_q == 3'd7) && serial_ready_i && !frame_last_q;
                if (serial_ready_i) begin
                    shreg_d = {1'b0, shreg_q[7:1]};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        if (!frame_last_q) begin
                            if (byte_valid_i) begin
                                shreg_d      = data_parallel_i;
                                frame_last_d = byte_last_i;
                                cnt_d        = 3'd0;
                            end else begin
                                state_d = IDLE;
                            end
                        end else begin
`ifdef PISO_TAIL_FLUSH_EN
                            state_d    = TAIL;
                            tail_cnt_d = 4'd0;
`else
                            state_d    = IDLE;
`endif
                        end
                    end
                end
            end
`ifdef PISO_TAIL_FLUSH_EN
            TAIL: begin
                // The shift register is already all zeros here, so the tail bits come out as 0.
                if (serial_ready_i) begin
                    if (tail_cnt_q == TAIL_END) begin
                        state_d    = IDLE;
                        tail_cnt_d = 4'd0;
                    end else begin
                        tail_cnt_d = tail_cnt_q + 4'd1;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        valid_d = (state_d != IDLE);
`ifdef PISO_TAIL_FLUSH_EN
        last_out_d = (state_d == TAIL) && (tail_cnt_d == TAIL_END);
`else
        last_out_d = (state_d == SHIFT) && (cnt_d == 3'd7) && frame_last_d;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shreg_q      <= 8'd0;
            cnt_q        <= 3'd0;
            frame_last_q <= 1'b0;
            ready_en_q   <= 1'b0;
            valid_q      <= 1'b0;
            last_out_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            frame_last_q <= frame_last_d;
            ready_en_q   <= 1'b1;
            valid_q      <= valid_d;
            last_out_q   <= last_out_d;
        end
    end

`ifdef PISO_TAIL_FLUSH_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tail_cnt_q <= 4'd0;
        end else begin
            tail_cnt_q <= tail_cnt_d;
        end
    end
`endif

    assign data_serial_o  = shreg_q[0];
    assign valid_serial_o = valid_q;
    assign last_serial_o  = last_out_q;
    assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_piso.sv
// Directed bench for piso: reset, single frame, back-to-back bytes, backpressure,
// reset mid-byte and a held byte_valid_i; tail bits are expected when PISO_TAIL_FLUSH_EN is defined.
module tb_piso;

    localparam int TAIL_BITS = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_parallel_i;
    logic       byte_valid_i;
    logic       byte_last_i;
    logic       byte_ready_o;
    logic       data_serial_o;
    logic       valid_serial_o;
    logic       serial_ready_i;
    logic       last_serial_o;
    logic       busy_o;

    logic [0:0] exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    piso #(.TAIL_BITS(TAIL_BITS)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .data_parallel_i (data_parallel_i),
        .byte_valid_i    (byte_valid_i),
        .byte_last_i     (byte_last_i),
        .byte_ready_o    (byte_ready_o),
        .data_serial_o   (data_serial_o),
        .valid_serial_o  (valid_serial_o),
        .serial_ready_i  (serial_ready_i),
        .last_serial_o   (last_serial_o),
        .busy_o          (busy_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
    endtask

    task automatic push_tail();
`ifdef PISO_TAIL_FLUSH_EN
        for (int i = 0; i < TAIL_BITS; i++) exp_q.push_back(1'b0);
`endif
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        data_parallel_i = b;
        byte_last_i     = last;
        byte_valid_i    = 1'b1;
        #1;
        check("accept_ready", byte_ready_o, 1);
        step();
        byte_valid_i = 1'b0;
    endtask

    // Pops one expected bit per transfer; optionally injects (or holds) a byte
    // until transfer index inject_at and stalls serial_ready_i at stall_at.
    task automatic drain(input int inject_at, input logic hold, input logic [7:0] inj_data,
                         input logic inj_last, input int stall_at, input int stall_len);
        logic e;
        logic is_last;
        int   idx;
        idx = 0;
        if (hold) begin
            data_parallel_i = inj_data;
            byte_last_i     = inj_last;
            byte_valid_i    = 1'b1;
        end
        while (exp_q.size() > 0 && idx < 64) begin
            e       = exp_q.pop_front();
            is_last = (exp_q.size() == 0);
            if (idx == stall_at) begin
                serial_ready_i = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    #1;
                    check("stall_valid", valid_serial_o, 1);
                    check("stall_data", data_serial_o, e);
                    check("stall_last", last_serial_o, is_last);
                    check("stall_ready", byte_ready_o, 0);
                    step();
                end
                serial_ready_i = 1'b1;
            end
            if (idx == inject_at) begin
                data_parallel_i = inj_data;
                byte_last_i     = inj_last;
                byte_valid_i    = 1'b1;
            end
            #1;
            check("bit_valid", valid_serial_o, 1);
            check("bit_data", data_serial_o, e);
            check("bit_last", last_serial_o, is_last);
            check("bit_busy", busy_o, 1);
            if (idx == inject_at) check("stream_ready", byte_ready_o, 1);
            else if (hold && idx < inject_at) check("hold_ready", byte_ready_o, 0);
            step();
            if (idx == inject_at) byte_valid_i = 1'b0;
            idx++;
        end
        check("drain_bounded", (exp_q.size() == 0), 1);
        #1;
        check("end_valid", valid_serial_o, 0);
        check("end_busy", busy_o, 0);
        check("end_last", last_serial_o, 0);
        check("end_ready", byte_ready_o, 1);
    endtask

    initial begin
        rst_n           = 1'b0;
        data_parallel_i = 8'h00;
        byte_valid_i    = 1'b0;
        byte_last_i     = 1'b0;
        serial_ready_i  = 1'b0;

        // Reset with random inputs: everything low.
        for (int i = 0; i < 4; i++) begin
            data_parallel_i = 8'($urandom_range(0, 255));
            byte_valid_i    = 1'($urandom_range(0, 1));
            byte_last_i     = 1'($urandom_range(0, 1));
            serial_ready_i  = 1'($urandom_range(0, 1));
            #1;
            check("rst_data", data_serial_o, 0);
            check("rst_valid", valid_serial_o, 0);
            check("rst_last", last_serial_o, 0);
            check("rst_busy", busy_o, 0);
            check("rst_ready", byte_ready_o, 0);
            step();
        end
        byte_valid_i   = 1'b0;
        serial_ready_i = 1'b1;
        rst_n          = 1'b1;
        #1;
        check("ready_first_cycle", byte_ready_o, 0);
        step();
        check("ready_after_reset", byte_ready_o, 1);

        // Single frame 0xA5: 1,0,1,0,0,1,0,1 (+ zero tail when enabled).
        push_byte(8'hA5);
        push_tail();
        send_byte(8'hA5, 1'b1);
        drain(-1, 1'b0, 8'h00, 1'b0, -1, 0);
        step();

        // Back-to-back 0x01 then 0x80, second accepted on bit 7 of the first.
        push_byte(8'h01);
        push_byte(8'h80);
        push_tail();
        send_byte(8'h01, 1'b0);
        drain(7, 1'b0, 8'h80, 1'b1, -1, 0);
        step();

        // Backpressure on bit 3 of 0x3C for 5 cycles.
        push_byte(8'h3C);
        push_tail();
        send_byte(8'h3C, 1'b1);
        drain(-1, 1'b0, 8'h00, 1'b0, 3, 5);
        step();

        // Reset after four transfers of 0xFF; then 0x00 must come out clean.
        send_byte(8'hFF, 1'b1);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("ff_data", data_serial_o, 1);
            check("ff_valid", valid_serial_o, 1);
            step();
        end
        rst_n = 1'b0;
        #1;
        check("midrst_valid", valid_serial_o, 0);
        check("midrst_data", data_serial_o, 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_ready", byte_ready_o, 0);
        step();
        rst_n = 1'b1;
        step();
        push_byte(8'h00);
        push_tail();
        send_byte(8'h00, 1'b1);
        drain(-1, 1'b0, 8'h00, 1'b0, -1, 0);
        step();

        // 0x55 held valid through 0xC3; accepted only on 0xC3's bit 7, sent once.
        push_byte(8'hC3);
        push_byte(8'h55);
        push_tail();
        send_byte(8'hC3, 1'b0);
        drain(7, 1'b1, 8'h55, 1'b1, -1, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("once_valid", valid_serial_o, 0);
            check("once_busy", busy_o, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
